// File: rtl/multicycle_addsub.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_addsub
// Description : Ripple-chunk adder/subtractor. It processes CHUNK bits per
//               clock and uses a valid/ready handshake on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_nchunk = WIDTH / CHUNK;
    localparam int c_kw     = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
    localparam logic [c_kw-1:0] c_last_idx = c_kw'(c_nchunk - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [c_kw-1:0]  r_k;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic             w_msb_cin;

    assign w_a_chunk   = r_a[r_k*CHUNK +: CHUNK];
    assign w_b_chunk   = r_b[r_k*CHUNK +: CHUNK];
    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    // Carry into the top bit is recovered from that bit's sum and operand bits
    assign w_msb_cin   = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];

    assign in_ready  = (r_state == c_idle) && !rst;
    assign out_valid = (r_state == c_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= cin ^ sub;
                        r_k     <= '0;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    sum[r_k*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
                    r_carry                 <= w_chunk_sum[CHUNK];
                    r_k                     <= r_k + 1'b1;
                    if (r_k == c_last_idx) begin
                        cout    <= w_chunk_sum[CHUNK];
                        ovf     <= w_msb_cin ^ w_chunk_sum[CHUNK];
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
